// File: rtl/siw_addr_gen_5.sv
// siw_addr_gen_5: 2-D address walker for port A of siw_memory_bram_5.
// Optional modulo wrap of the offset when SIW_ADDR_GEN_MOD_EN is defined.
module siw_addr_gen_5 #(
  parameter int ADDR_W = 10
) (
  input  logic              siw_addr_gen_5_clk,
  input  logic              siw_addr_gen_5_reset,
  input  logic              siw_addr_gen_5_init,
  input  logic              siw_addr_gen_5_run,
  input  logic              siw_addr_gen_5_pause,
  input  logic [ADDR_W-1:0] siw_addr_gen_5_start,
  input  logic [ADDR_W-1:0] siw_addr_gen_5_incr,
  input  logic [ADDR_W-1:0] siw_addr_gen_5_iter,
  input  logic [ADDR_W-1:0] siw_addr_gen_5_shift,
  input  logic [ADDR_W-1:0] siw_addr_gen_5_per,
  input  logic [ADDR_W-1:0] siw_addr_gen_5_delay,
  input  logic              siw_addr_gen_5_wr_mode,
`ifdef SIW_ADDR_GEN_MOD_EN
  input  logic [ADDR_W-1:0] siw_addr_gen_5_modulo,
`endif
  output logic [ADDR_W-1:0] siw_addr_gen_5_address,
  output logic              siw_addr_gen_5_enable,
  output logic              siw_addr_gen_5_write_en,
  output logic              siw_addr_gen_5_busy,
  output logic              siw_addr_gen_5_done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] incr_q;
  logic [ADDR_W-1:0] iter_q;
  logic [ADDR_W-1:0] shift_q;
  logic [ADDR_W-1:0] per_q;
  logic [ADDR_W-1:0] delay_q;
  logic              wr_q;
`ifdef SIW_ADDR_GEN_MOD_EN
  logic [ADDR_W-1:0] mod_q;
`endif

  logic [ADDR_W-1:0] dly_cnt;
  logic [ADDR_W-1:0] in_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic [ADDR_W-1:0] ioff;
  logic [ADDR_W-1:0] roff;
  logic [ADDR_W-1:0] inner_nxt;
  logic [ADDR_W-1:0] row_nxt;

  logic emit;
  logic last_in;
  logic last_out;
  logic empty;

  assign last_in  = (in_cnt == iter_q - ONE);
  assign last_out = (out_cnt == per_q - ONE);
  assign empty    = (iter_q == '0) || (per_q == '0);

  assign siw_addr_gen_5_busy = (state == DELAY) || (state == RUN);

`ifdef SIW_ADDR_GEN_MOD_EN
  logic [ADDR_W:0] inner_sum;
  logic [ADDR_W:0] row_sum;

  // Offset steps fold back into [0, modulo) when modulo is non-zero
  always_comb begin
    inner_sum = {1'b0, ioff} + {1'b0, incr_q};
    row_sum   = {1'b0, roff} + {1'b0, shift_q};
    if (mod_q != '0 && inner_sum >= {1'b0, mod_q})
      inner_sum = inner_sum - {1'b0, mod_q};
    if (mod_q != '0 && row_sum >= {1'b0, mod_q})
      row_sum = row_sum - {1'b0, mod_q};
    inner_nxt = inner_sum[ADDR_W-1:0];
    row_nxt   = row_sum[ADDR_W-1:0];
  end
`else
  // Offset steps wrap naturally at 2^ADDR_W
  always_comb begin
    inner_nxt = ioff + incr_q;
    row_nxt   = roff + shift_q;
  end
`endif

  // State register; init aborts like reset
  always_ff @(posedge siw_addr_gen_5_clk) begin
    if (siw_addr_gen_5_reset || siw_addr_gen_5_init)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state and access-issue decode
  always_comb begin
    state_n = state;
    emit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (siw_addr_gen_5_run) begin
          if (empty)
            state_n = DONE;
          else if (delay_q != '0)
            state_n = DELAY;
          else
            state_n = RUN;
        end
      end
      DELAY: begin
        if (!siw_addr_gen_5_pause && dly_cnt == ONE)
          state_n = RUN;
      end
      RUN: begin
        if (!siw_addr_gen_5_pause) begin
          emit = 1'b1;
          if (last_in && last_out)
            state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Config capture, loop counters and registered outputs
  always_ff @(posedge siw_addr_gen_5_clk) begin
    if (siw_addr_gen_5_reset) begin
      start_q <= '0;
      incr_q  <= '0;
      iter_q  <= '0;
      shift_q <= '0;
      per_q   <= '0;
      delay_q <= '0;
      wr_q    <= 1'b0;
`ifdef SIW_ADDR_GEN_MOD_EN
      mod_q   <= '0;
`endif
      dly_cnt <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      ioff    <= '0;
      roff    <= '0;
      siw_addr_gen_5_address  <= '0;
      siw_addr_gen_5_enable   <= 1'b0;
      siw_addr_gen_5_write_en <= 1'b0;
      siw_addr_gen_5_done     <= 1'b0;
    end else if (siw_addr_gen_5_init) begin
      start_q <= siw_addr_gen_5_start;
      incr_q  <= siw_addr_gen_5_incr;
      iter_q  <= siw_addr_gen_5_iter;
      shift_q <= siw_addr_gen_5_shift;
      per_q   <= siw_addr_gen_5_per;
      delay_q <= siw_addr_gen_5_delay;
      wr_q    <= siw_addr_gen_5_wr_mode;
`ifdef SIW_ADDR_GEN_MOD_EN
      mod_q   <= siw_addr_gen_5_modulo;
`endif
      dly_cnt <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      ioff    <= '0;
      roff    <= '0;
      siw_addr_gen_5_address  <= '0;
      siw_addr_gen_5_enable   <= 1'b0;
      siw_addr_gen_5_write_en <= 1'b0;
      siw_addr_gen_5_done     <= 1'b0;
    end else begin
      siw_addr_gen_5_enable   <= emit;
      siw_addr_gen_5_write_en <= emit & wr_q;
      siw_addr_gen_5_done     <= (state == DONE);
      if (state == IDLE && siw_addr_gen_5_run) begin
        dly_cnt <= delay_q;
        in_cnt  <= '0;
        out_cnt <= '0;
        ioff    <= '0;
        roff    <= '0;
      end
      if (state == DELAY && !siw_addr_gen_5_pause)
        dly_cnt <= dly_cnt - ONE;
      if (emit) begin
        siw_addr_gen_5_address <= start_q + ioff;
        if (last_in) begin
          in_cnt  <= '0;
          out_cnt <= out_cnt + ONE;
          roff    <= row_nxt;
          ioff    <= row_nxt;
        end else begin
          in_cnt  <= in_cnt + ONE;
          ioff    <= inner_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_siw_addr_gen_5.sv
// tb_siw_addr_gen_5: directed vectors for siw_addr_gen_5.
// Define SIW_ADDR_GEN_MOD_EN to also cover the modulo build.
module tb_siw_addr_gen_5;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         init;
  logic         run;
  logic         pause;
  logic [W-1:0] start;
  logic [W-1:0] incr;
  logic [W-1:0] iter;
  logic [W-1:0] shift;
  logic [W-1:0] per;
  logic [W-1:0] delay;
  logic         wr_mode;
`ifdef SIW_ADDR_GEN_MOD_EN
  logic [W-1:0] modulo;
`endif
  logic [W-1:0] address;
  logic         enable;
  logic         write_en;
  logic         busy;
  logic         done;

  siw_addr_gen_5 #(.ADDR_W(W)) dut (
    .siw_addr_gen_5_clk      (clk),
    .siw_addr_gen_5_reset    (reset),
    .siw_addr_gen_5_init     (init),
    .siw_addr_gen_5_run      (run),
    .siw_addr_gen_5_pause    (pause),
    .siw_addr_gen_5_start    (start),
    .siw_addr_gen_5_incr     (incr),
    .siw_addr_gen_5_iter     (iter),
    .siw_addr_gen_5_shift    (shift),
    .siw_addr_gen_5_per      (per),
    .siw_addr_gen_5_delay    (delay),
    .siw_addr_gen_5_wr_mode  (wr_mode),
`ifdef SIW_ADDR_GEN_MOD_EN
    .siw_addr_gen_5_modulo   (modulo),
`endif
    .siw_addr_gen_5_address  (address),
    .siw_addr_gen_5_enable   (enable),
    .siw_addr_gen_5_write_en (write_en),
    .siw_addr_gen_5_busy     (busy),
    .siw_addr_gen_5_done     (done)
  );

  typedef struct packed {
    logic [W-1:0]      start;
    logic [W-1:0]      incr;
    logic [W-1:0]      iter;
    logic [W-1:0]      shift;
    logic [W-1:0]      per;
    logic [W-1:0]      delay;
    logic [W-1:0]      modulo;
    logic              wr;
    int                n;
    logic [0:7][W-1:0] a;
  } scn_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic scn_t mk(input int st, input int in,
                              input int it, input int sh,
                              input int pe, input int de,
                              input int md, input bit wr,
                              input int n,
                              input logic [0:7][W-1:0] a);
    scn_t s;
    s.start  = W'(st);
    s.incr   = W'(in);
    s.iter   = W'(it);
    s.shift  = W'(sh);
    s.per    = W'(pe);
    s.delay  = W'(de);
    s.modulo = W'(md);
    s.wr     = wr;
    s.n      = n;
    s.a      = a;
    return s;
  endfunction

  task automatic load_cfg(input scn_t s);
    start   = s.start;
    incr    = s.incr;
    iter    = s.iter;
    shift   = s.shift;
    per     = s.per;
    delay   = s.delay;
    wr_mode = s.wr;
`ifdef SIW_ADDR_GEN_MOD_EN
    modulo  = s.modulo;
`endif
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic go(input scn_t s, input string tag);
    int k;
    int first;
    int last;
    int dt;
    int cyc;
    int bc;
    run = 1'b1;
    tick();
    run = 1'b0;
    start = W'($urandom);
    incr  = W'($urandom);
    iter  = W'($urandom);
    shift = W'($urandom);
    per   = W'($urandom);
    delay = W'($urandom);
    wr_mode = ~s.wr;
    bc = busy ? 1 : 0;
    k = 0;
    first = -1;
    last = -1;
    dt = -1;
    cyc = 0;
    while (cyc < 200 && dt < 0) begin
      tick();
      cyc++;
      if (busy) bc++;
      if (enable) begin
        if (first < 0) first = cyc;
        if (k < s.n) begin
          chk($sformatf("%s_addr%0d", tag, k), 32'(address),
              32'(s.a[k]));
          chk($sformatf("%s_we%0d", tag, k), 32'(write_en),
              32'(s.wr));
        end
        k++;
        last = cyc;
      end
      if (done) dt = cyc;
    end
    if (dt < 0) begin
      failures++;
      $display("FAIL %s_timeout: got no done expected done", tag);
    end
    chk({tag, "_count"}, k, s.n);
    if (s.n > 0) begin
      chk({tag, "_latency"}, first, 32'(s.delay) + 1);
      chk({tag, "_done_gap"}, dt, last + 1);
      chk({tag, "_busy"}, bc, 32'(s.delay) + s.n);
    end else begin
      chk({tag, "_done_gap"}, dt, 1);
      chk({tag, "_busy"}, bc, 0);
    end
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  scn_t tbl[$];

  initial begin
    scn_t sa;
    scn_t sb;
    logic en_e[9];
    int   ad_e[9];
    logic dn_e[9];
    int   seen;

    reset = 1'b1;
    init = 1'b0;
    run = 1'b0;
    pause = 1'b0;
    start = '0;
    incr = '0;
    iter = '0;
    shift = '0;
    per = '0;
    delay = '0;
    wr_mode = 1'b0;
`ifdef SIW_ADDR_GEN_MOD_EN
    modulo = '0;
`endif

    tbl.push_back(mk(16, 1, 4, 0, 1, 0, 0, 1, 4,
      {10'd16, 10'd17, 10'd18, 10'd19,
       10'd0, 10'd0, 10'd0, 10'd0}));
    tbl.push_back(mk(0, 2, 3, 32, 2, 0, 0, 0, 6,
      {10'd0, 10'd2, 10'd4, 10'd32,
       10'd34, 10'd36, 10'd0, 10'd0}));
    tbl.push_back(mk(1022, 1, 4, 0, 1, 0, 0, 1, 4,
      {10'd1022, 10'd1023, 10'd0, 10'd1,
       10'd0, 10'd0, 10'd0, 10'd0}));
    tbl.push_back(mk(5, 1, 0, 0, 1, 0, 0, 1, 0, '0));
    tbl.push_back(mk(8, 1, 3, 0, 1, 3, 0, 0, 3,
      {10'd8, 10'd9, 10'd10, 10'd0,
       10'd0, 10'd0, 10'd0, 10'd0}));
    tbl.push_back(mk(10, 1023, 2, 1020, 3, 0, 0, 1, 6,
      {10'd10, 10'd9, 10'd6, 10'd5,
       10'd2, 10'd1, 10'd0, 10'd0}));
    tbl.push_back(mk(7, 1, 3, 0, 0, 2, 0, 1, 0, '0));
`ifdef SIW_ADDR_GEN_MOD_EN
    tbl.push_back(mk(100, 3, 5, 0, 1, 0, 8, 1, 5,
      {10'd100, 10'd103, 10'd106, 10'd101,
       10'd104, 10'd0, 10'd0, 10'd0}));
`endif

    tick();
    tick();
    reset = 1'b0;
    chk("rst_address", 32'(address), 0);
    chk("rst_enable", {31'd0, enable}, 0);
    chk("rst_write_en", {31'd0, write_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      load_cfg(tbl[i]);
      go(tbl[i], $sformatf("vec%0d", i));
    end

    // pause on the second RUN cycle after a 3-cycle delay
    load_cfg(mk(40, 1, 4, 0, 1, 3, 0, 1, 4, '0));
    en_e = '{0, 0, 0, 1, 0, 1, 1, 1, 0};
    ad_e = '{0, 0, 0, 40, 40, 41, 42, 43, 43};
    dn_e = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      pause = (t == 5);
      tick();
      pause = 1'b0;
      chk($sformatf("pause_en_t%0d", t), {31'd0, enable},
          {31'd0, en_e[t-1]});
      chk($sformatf("pause_addr_t%0d", t), 32'(address), ad_e[t-1]);
      chk($sformatf("pause_done_t%0d", t), {31'd0, done},
          {31'd0, dn_e[t-1]});
    end

    // init mid-RUN aborts; new run uses new config
    sa = mk(200, 1, 8, 0, 1, 0, 0, 1, 8, '0);
    sb = mk(300, 2, 2, 0, 1, 0, 0, 1, 2,
      {10'd300, 10'd302, 10'd0, 10'd0,
       10'd0, 10'd0, 10'd0, 10'd0});
    load_cfg(sa);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_pre_addr", 32'(address), 202);
    load_cfg(sb);
    chk("abort_enable", {31'd0, enable}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (done || enable) seen++;
    end
    chk("abort_quiet", seen, 0);
    go(sb, "abort_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
